// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the request side and the output FIFO side of instr_encoder.
//   DEPTH must match the DEPTH of the instr_encoder instance it connects to,
//   because it sizes the occupancy count.
//
//   Request side : in_valid, in_ready, in_kind, in_rd, in_rs1, in_rs2,
//                  in_funct3, in_funct7, in_imm
//   Output side  : out_valid, out_ready, out_instr, out_err, count
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both high. The sender holds its payload stable
//   while valid is high and ready is low. ready never depends on valid.
//
//   Modports: master = request producer / output consumer (bench, injector),
//             slave  = the encoder itself.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [10:0]   in_kind;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;

    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, count
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   RV32I instruction encoder: the inverse of the opcode decode stage. A
//   request carries a one-hot instruction kind plus register, funct and
//   immediate fields; the fields are packed combinationally into a 32-bit
//   RV32I word and the word is written into a DEPTH-entry FIFO on push.
//   Requests that cannot be encoded (bad kind, immediate out of range or
//   misaligned) are still queued, but as out_instr = 0 with out_err = 1.
//
//   Ports
//     clk   in  clock, all state updates on posedge
//     rst   in  asynchronous active-low reset; discards all queued entries
//     bus   slave modport of instr_encoder_if:
//           in_valid/in_ready      request handshake
//           in_kind[10:0]          [0]lui [1]auipc [2]jal [3]jalr [4]branch
//                                  [5]load [6]store [7]imm_arith [8]reg_arith
//                                  [9]fence [10]system
//           in_rd/in_rs1/in_rs2    register numbers
//           in_funct3/in_funct7    funct fields (funct7 used by reg_arith)
//           in_imm[31:0]           unshifted two's complement immediate
//           out_valid/out_ready    FIFO head handshake
//           out_instr[31:0]        encoded word at FIFO head
//           out_err                head entry was not encodable
//           count                  FIFO occupancy
// ---------------------------------------------------------------------------
module instr_encoder #(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Kind bit positions
    localparam int K_LUI    = 0;
    localparam int K_AUIPC  = 1;
    localparam int K_JAL    = 2;
    localparam int K_JALR   = 3;
    localparam int K_BRANCH = 4;
    localparam int K_LOAD   = 5;
    localparam int K_STORE  = 6;
    localparam int K_IMM    = 7;
    localparam int K_REG    = 8;
    localparam int K_FENCE  = 9;
    localparam int K_SYSTEM = 10;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ------------------------------------------------------------------
    // Combinational encode of the current request fields
    // ------------------------------------------------------------------
    logic        kind_onehot;
    logic        i_imm_ok;
    logic        b_imm_ok;
    logic        j_imm_ok;
    logic        u_imm_ok;
    logic        fmt_ok;
    logic [31:0] fmt_word;
    logic        enc_err;
    logic [31:0] enc_instr;

    always_comb begin
        // Clearing the lowest set bit leaves zero only for a single set bit.
        kind_onehot = (bus.in_kind != 11'd0) &&
                      ((bus.in_kind & (bus.in_kind - 11'd1)) == 11'd0);

        // An immediate fits a signed N-bit field when every bit from the
        // field's sign bit upward carries the same value.
        i_imm_ok = (&bus.in_imm[31:11]) | ~(|bus.in_imm[31:11]);
        b_imm_ok = ((&bus.in_imm[31:12]) | ~(|bus.in_imm[31:12])) & ~bus.in_imm[0];
        j_imm_ok = ((&bus.in_imm[31:20]) | ~(|bus.in_imm[31:20])) & ~bus.in_imm[0];
        u_imm_ok = (bus.in_imm[11:0] == 12'd0);

        fmt_ok   = 1'b0;
        fmt_word = 32'd0;

        if (bus.in_kind[K_LUI]) begin
            fmt_word = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
            fmt_ok   = u_imm_ok;
        end else if (bus.in_kind[K_AUIPC]) begin
            fmt_word = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
            fmt_ok   = u_imm_ok;
        end else if (bus.in_kind[K_JAL]) begin
            fmt_word = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11],
                        bus.in_imm[19:12], bus.in_rd, OP_JAL};
            fmt_ok   = j_imm_ok;
        end else if (bus.in_kind[K_JALR]) begin
            fmt_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_JALR};
            fmt_ok   = i_imm_ok;
        end else if (bus.in_kind[K_BRANCH]) begin
            fmt_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                        bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
            fmt_ok   = b_imm_ok;
        end else if (bus.in_kind[K_LOAD]) begin
            fmt_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
            fmt_ok   = i_imm_ok;
        end else if (bus.in_kind[K_STORE]) begin
            fmt_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_imm[4:0], OP_STORE};
            fmt_ok   = i_imm_ok;
        end else if (bus.in_kind[K_IMM]) begin
            // Shift amounts and the arithmetic-shift funct7 bit arrive via imm.
            fmt_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
            fmt_ok   = i_imm_ok;
        end else if (bus.in_kind[K_REG]) begin
            fmt_word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3,
                        bus.in_rd, OP_REG};
            fmt_ok   = 1'b1;
        end else if (bus.in_kind[K_FENCE]) begin
            // fm/pred/succ bits arrive via imm.
            fmt_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_FENCE};
            fmt_ok   = i_imm_ok;
        end else if (bus.in_kind[K_SYSTEM]) begin
            // CSR address / ECALL-EBREAK selector arrive via imm.
            fmt_word = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_SYSTEM};
            fmt_ok   = i_imm_ok;
        end

        enc_err   = !kind_onehot || !fmt_ok;
        enc_instr = enc_err ? 32'd0 : fmt_word;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]   mem_instr_q [DEPTH];
    logic          mem_err_q   [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          push;
    logic          pop;
    logic          in_ready_w;
    logic          out_valid_w;

    // in_ready looks only at the current occupancy, so a pop on a full FIFO
    // does not open the input in the same cycle. Held low during reset.
    assign in_ready_w  = rst && (count_q != FULL);
    assign out_valid_w = (count_q != '0);

    assign push = bus.in_valid  & in_ready_w;
    assign pop  = bus.out_ready & out_valid_w;

    always_comb begin
        // DEPTH is a power of two, so pointer overflow is the mod-DEPTH wrap.
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= 32'd0;
                mem_err_q[i]   <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_instr_q[wr_ptr_q] <= enc_instr;
                mem_err_q[wr_ptr_q]   <= enc_err;
            end
        end
    end

    // Stale slots are never shown: an empty FIFO reads as zero.
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_instr = out_valid_w ? mem_instr_q[rd_ptr_q] : 32'd0;
    assign bus.out_err   = out_valid_w ? mem_err_q[rd_ptr_q]   : 1'b0;
    assign bus.count     = count_q;

endmodule
